// File: rtl/adder_pkg.sv
// Shared types and default sizing for the multi-word sequential adder.
// The slice sequencer state enum lives here so benches can decode the debug state.
package adder_pkg;

  localparam int DEF_CHUNK  = 8;
  localparam int DEF_NCHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
// The sub field exists only when MWADD_SUB_EN is defined.
interface multiword_add_seq_if #(
    parameter int CHUNK  = adder_pkg::DEF_CHUNK,
    parameter int NCHUNK = adder_pkg::DEF_NCHUNK
);
    localparam int WIDTH = CHUNK * NCHUNK;

    // Valid/ready: a transfer happens on a rising edge where valid && ready are both
    // high; the sender holds valid and its payload steady until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef MWADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin,
`ifdef MWADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
        output in_valid, a, b, cin,
`ifdef MWADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/ripplefullfadder_x.sv
// Combinational ripple-carry adder of chainnumber bits; the shared slice datapath.
module ripplefullfadder_x #(
    parameter int chainnumber = 8
) (
    input  logic [chainnumber-1:0] a,
    input  logic [chainnumber-1:0] b,
    input  logic                   cin,
    output logic [chainnumber-1:0] s,
    output logic                   cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < chainnumber; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two CHUNK*NCHUNK-bit operands one CHUNK-bit slice per cycle through a shared ripple adder.
// Optional subtract mode when MWADD_SUB_EN is defined.
module multiword_add_seq
    import adder_pkg::*;
#(
    parameter int CHUNK  = DEF_CHUNK,
    parameter int NCHUNK = DEF_NCHUNK
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    multiword_add_seq_if.slave    bus,
    output state_t                dbg_state
);

    localparam int WIDTH = CHUNK * NCHUNK;
    localparam int KW    = $clog2(NCHUNK);
    localparam int BW    = $clog2(WIDTH);
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q;
    logic [KW-1:0]    k_q;
    logic [BW-1:0]    base;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic             sub_req;

`ifdef MWADD_SUB_EN
    assign sub_req = bus.sub;
`else
    assign sub_req = 1'b0;
`endif

    assign base = BW'(k_q) * BW'(CHUNK);

    ripplefullfadder_x #(.chainnumber(CHUNK)) u_slice (
        .a    (a_q[base +: CHUNK]),
        .b    (b_q[base +: CHUNK]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    // Subtraction is a + ~b + 1, so the incoming cin is dropped.
                    a_q     <= bus.a;
                    b_q     <= sub_req ? ~bus.b : bus.b;
                    carry_q <= sub_req ? 1'b1 : bus.cin;
                    k_q     <= '0;
                end
                RUN: begin
                    sum_q[base +: CHUNK] <= slice_s;
                    carry_q              <= slice_c;
                    if (k_q == KLAST) cout_q <= slice_c;
                    else              k_q    <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (k_q == KLAST) state_nx = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed vectors, arithmetic reference model and scoreboard.
module tb_multiword_add_seq;
    import adder_pkg::*;

    localparam int CHUNK  = 8;
    localparam int NCHUNK = 4;
    localparam int WIDTH  = CHUNK * NCHUNK;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiword_add_seq_if #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) bus ();
    state_t dbg_state;

    multiword_add_seq #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
        .clk1      (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit btb_mode = 1'b0;
    logic [WIDTH:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {cout, sum} from plain integer arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
        logic [WIDTH-1:0] diff;
        if (s) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Monitor/scoreboard: sampled on the falling edge, away from the active edge.
    logic ov_prev = 1'b0;
    bit   have_prev = 1'b0;
    int   acc_cyc = 0;
    int   prev_acc = 0;
    logic sub_v;
    always @(negedge clk) begin
`ifdef MWADD_SUB_EN
        sub_v = bus.sub;
`else
        sub_v = 1'b0;
`endif
        if (!btb_mode) have_prev = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.cin, sub_v));
                if (btb_mode && have_prev) check("accept_spacing", 64'(cyc - prev_acc), 64'(NCHUNK + 2));
                prev_acc  = cyc;
                have_prev = 1'b1;
                acc_cyc   = cyc;
            end
            if (bus.out_valid) begin
                if (!ov_prev) check("latency", 64'(cyc - acc_cyc), 64'(NCHUNK + 1));
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("result", 64'({bus.cout, bus.sum}), 64'(exp_q[0]));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic s);
        int n;
        bus.a   = a;
        bus.b   = b;
        bus.cin = c;
`ifdef MWADD_SUB_EN
        bus.sub = s;
`else
        if (s) $display("send: sub ignored in add-only build");
`endif
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) check("accept_timeout", 64'd1, 64'd0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) check("out_valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input logic [WIDTH:0] lit);
        send(a, b, c, s);
        wait_valid();
        check(name, 64'({bus.cout, bus.sum}), 64'(lit));
        take();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_sum"},       64'(bus.sum),       64'd0);
        check({tag, "_cout"},      64'(bus.cout),      64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef MWADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        tick();
        tick();
        check_reset_outputs("reset");
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;
        tick();

        // Carry from slice 0 into slice 1; latency checked by the monitor.
        run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 32'h0000_0100});
        // Carry rippling through every slice.
        run_op("add_ffffffff_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b1, 32'h0000_0000});
        run_op("add_mixed", 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0, {1'b1, 32'h0000_0002});

        // Stall in DONE with a competing request that must not be taken.
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        wait_valid();
        check("stall_first", 64'({bus.cout, bus.sum}), 64'({1'b0, 32'hACF1_3568}));
        bus.a        = 32'h1111_1111;
        bus.b        = 32'h2222_2222;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_in_ready",  64'(bus.in_ready),  64'd0);
            check("stall_sum",       64'({bus.cout, bus.sum}), 64'({1'b0, 32'hACF1_3568}));
        end
        take();
        check("after_take_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_valid();
        check("stall_second", 64'({bus.cout, bus.sum}), 64'({1'b0, 32'h3333_3333}));
        take();

        // Asynchronous abort two cycles into RUN.
        send(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);
        tick();
        tick();
        check("pre_abort_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_abort_in_ready", 64'(bus.in_ready), 64'd1);
        run_op("add_3_4", 32'd3, 32'd4, 1'b0, 1'b0, {1'b0, 32'd7});

`ifdef MWADD_SUB_EN
        run_op("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b1, {1'b0, 32'hFFFF_FFFE});
        run_op("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, {1'b1, 32'h0000_0002});
        bus.sub = 1'b0;
`endif

        // Back-to-back with the consumer always ready.
        btb_mode      = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.cin      = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 100) begin
                tick();
                n++;
            end
            if (n == 100) check("btb_accept_timeout", 64'd1, 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) check("btb_drain_timeout", 64'd1, 64'd0);
        btb_mode      = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
